// File: rtl/rail_seq_pkg.sv
// ============================================================================
// Module      : rail_seq_pkg
// Description : Shared state encoding and index-width helper for the rail
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rail_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_UP_EN     = 3'd1,
    ST_UP_WAIT   = 3'd2,
    ST_UP_SETTLE = 3'd3,
    ST_ON        = 3'd4,
    ST_DN_EN     = 3'd5,
    ST_DN_WAIT   = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  // Never narrower than one bit so a single-rail build still has an index.
  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pg_sync.sv
// ============================================================================
// Module      : pg_sync
// Description : Multi-bit two-flop synchronizer for raw power-good inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pg_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/rail_sequencer.sv
// ============================================================================
// Module      : rail_sequencer
// Description : Ordered power-rail sequencer: brings rails up one at a time
//               with power-good timeout and settle delay, takes them down in
//               reverse order. Optional macro RAIL_SEQ_PG_MONITOR_EN adds
//               power-good loss detection in UP_SETTLE and ON.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rail_sequencer
  import rail_seq_pkg::*;
#(
  parameter int                 N_RAILS      = 8,
  parameter int                 TIMER_W      = 24,
  parameter logic [TIMER_W-1:0] PG_TIMEOUT   = 24'h0f_ffff,
  parameter logic [TIMER_W-1:0] SETTLE_DELAY = 24'h03_ffff,
  parameter logic [TIMER_W-1:0] DOWN_DELAY   = 24'h03_ffff,
  parameter logic [N_RAILS-1:0] PG_MASK      = {N_RAILS{1'b1}}
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       power_up,
  input  logic                       power_down,
  input  logic [N_RAILS-1:0]         rail_pg,
  output logic [N_RAILS-1:0]         rail_en,
  output logic                       power_up_done,
  output logic                       power_down_done,
  output logic                       busy,
  output logic                       fault,
  output logic [IDX_W(N_RAILS)-1:0]  fault_rail
);

  localparam int            IW       = IDX_W(N_RAILS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_RAILS - 1);

  state_e               state_q,      state_d;
  logic [IW-1:0]        idx_q,        idx_d;
  logic [TIMER_W-1:0]   timer_q,      timer_d;
  logic [N_RAILS-1:0]   rail_en_q,    rail_en_d;
  logic                 up_done_q,    up_done_d;
  logic                 dn_done_q,    dn_done_d;
  logic                 fault_q,      fault_d;
  logic [IW-1:0]        fault_rail_q, fault_rail_d;

  logic [N_RAILS-1:0]   pg_s;
  logic [TIMER_W-1:0]   timer_dec;
  logic                 pg_lost_any;
  logic [IW-1:0]        pg_lost_idx;

  pg_sync #(
    .WIDTH   (N_RAILS)
  ) u_pg_sync (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .async_i (rail_pg),
    .sync_o  (pg_s)
  );

  assign timer_dec = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);

`ifdef RAIL_SEQ_PG_MONITOR_EN
  logic [N_RAILS-1:0] pg_lost;

  assign pg_lost     = PG_MASK & rail_en_q & ~pg_s;
  assign pg_lost_any = |pg_lost;

  // Downward scan leaves the lowest dropped rail as the reported index.
  always_comb begin
    pg_lost_idx = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (pg_lost[i]) pg_lost_idx = IW'(i);
    end
  end
`else
  assign pg_lost_any = 1'b0;
  assign pg_lost_idx = '0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    rail_en_d    = rail_en_q;
    up_done_d    = 1'b0;
    dn_done_d    = 1'b0;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;

    case (state_q)
      ST_OFF: begin
        if (power_down) begin
          dn_done_d = 1'b1;
        end else if (power_up) begin
          idx_d   = '0;
          state_d = ST_UP_EN;
        end
      end

      ST_UP_EN: begin
        if (power_down) begin
          state_d = ST_DN_EN;
        end else begin
          rail_en_d[idx_q] = 1'b1;
          timer_d          = PG_TIMEOUT;
          state_d          = ST_UP_WAIT;
        end
      end

      ST_UP_WAIT: begin
        if (power_down) begin
          state_d = ST_DN_EN;
        end else if (!PG_MASK[idx_q] || pg_s[idx_q]) begin
          timer_d = SETTLE_DELAY;
          state_d = ST_UP_SETTLE;
        end else if (timer_q == '0) begin
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = idx_q;
          state_d      = ST_FAULT;
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_UP_SETTLE: begin
        if (power_down) begin
          state_d = ST_DN_EN;
        end else if (pg_lost_any) begin
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = pg_lost_idx;
          state_d      = ST_FAULT;
        end else if (timer_q == '0) begin
          if (idx_q == LAST_IDX) begin
            up_done_d = 1'b1;
            state_d   = ST_ON;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_UP_EN;
          end
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_ON: begin
        if (power_down) begin
          idx_d   = LAST_IDX;
          state_d = ST_DN_EN;
        end else if (pg_lost_any) begin
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = pg_lost_idx;
          state_d      = ST_FAULT;
        end
      end

      ST_DN_EN: begin
        rail_en_d[idx_q] = 1'b0;
        timer_d          = DOWN_DELAY;
        state_d          = ST_DN_WAIT;
      end

      ST_DN_WAIT: begin
        if (timer_q == '0) begin
          if (idx_q == '0) begin
            dn_done_d = 1'b1;
            state_d   = ST_OFF;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_DN_EN;
          end
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_FAULT: begin
        if (power_down) begin
          fault_d      = 1'b0;
          fault_rail_d = '0;
          dn_done_d    = 1'b1;
          state_d      = ST_OFF;
        end
      end

      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      timer_q      <= '0;
      rail_en_q    <= '0;
      up_done_q    <= 1'b0;
      dn_done_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      rail_en_q    <= rail_en_d;
      up_done_q    <= up_done_d;
      dn_done_q    <= dn_done_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  assign rail_en         = rail_en_q;
  assign power_up_done   = up_done_q;
  assign power_down_done = dn_done_q;
  assign fault           = fault_q;
  assign fault_rail      = fault_rail_q;
  assign busy            = (state_q != ST_OFF) && (state_q != ST_ON) && (state_q != ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_rail_sequencer.sv
// ============================================================================
// Module      : tb_rail_sequencer
// Description : Scoreboard bench for rail_sequencer (3 rails, short delays).
//               Build with RAIL_SEQ_PG_MONITOR_EN to exercise pg-loss faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rail_sequencer;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pu = 1'b0;
  logic         pd = 1'b0;
  logic [N-1:0] pg_ok = '1;
  logic [N-1:0] rail_pg;
  logic [N-1:0] rail_en;
  logic         power_up_done, power_down_done, busy, fault;
  logic [1:0]   fault_rail;

  // Supplies report good as soon as they are enabled, unless held off.
  assign rail_pg = rail_en & pg_ok;

  always #5 clk = ~clk;

  rail_sequencer #(
    .N_RAILS      (N),
    .TIMER_W      (24),
    .PG_TIMEOUT   (24'd10),
    .SETTLE_DELAY (24'd4),
    .DOWN_DELAY   (24'd4),
    .PG_MASK      (3'b111)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .power_up        (pu),
    .power_down      (pd),
    .rail_pg         (rail_pg),
    .rail_en         (rail_en),
    .power_up_done   (power_up_done),
    .power_down_done (power_down_done),
    .busy            (busy),
    .fault           (fault),
    .fault_rail      (fault_rail)
  );

  // Expected output change; dt = cycles since previous change, 0 = unchecked.
  typedef struct {
    logic [N-1:0] en;
    logic         up;
    logic         dn;
    logic         bsy;
    logic         flt;
    logic [1:0]   fr;
    int           dt;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic push(input logic [N-1:0] en, input logic up, input logic dn,
                      input logic bsy, input logic flt, input logic [1:0] fr, input int dt);
    ev_t e;
    e.en = en; e.up = up; e.dn = dn; e.bsy = bsy; e.flt = flt; e.fr = fr; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // Monitor: every change of the observed output tuple must match the queue head.
  initial begin
    logic [8:0] prev, cur, want;
    ev_t e;
    int  gap;
    prev = '0;
    gap  = 0;
    forever begin
      @(negedge clk);
      gap++;
      cur = {rail_en, power_up_done, power_down_done, busy, fault, (fault ? fault_rail : 2'b00)};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event got=%b at %0t", cur, $time);
        end else begin
          e    = exp_q.pop_front();
          want = {e.en, e.up, e.dn, e.bsy, e.flt, (e.flt ? e.fr : 2'b00)};
          if (cur !== want || (e.dt > 0 && gap != e.dt)) begin
            miscompares++;
            $display("FAIL event got=%b gap=%0d exp=%b dt=%0d at %0t", cur, gap, want, e.dt, $time);
          end
        end
        prev = cur;
        gap  = 0;
      end
    end
  end

  task automatic pulse(input logic u, input logic d);
    @(negedge clk);
    pu = u;
    pd = d;
    @(negedge clk);
    pu = 1'b0;
    pd = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic up_seq();
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    push(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 9);
    push(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 9);
    push(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8);
    push(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b1, 1'b0);
    drain(200);
  endtask

  task automatic down_seq();
    push(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    push(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6);
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6);
    push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b0, 1'b1);
    drain(200);
  endtask

  initial begin
    #1;
    check("reset_outputs", {27'd0, rail_en, power_up_done, power_down_done},  32'd0);
    check("reset_status",  {29'd0, busy, fault, 1'b0},                          32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Nominal power-up, then power_up in ON must do nothing.
    up_seq();
    pulse(1'b1, 1'b0);
    idle(20);

    // Nominal power-down.
    down_seq();

    // Simultaneous strobes in OFF: power_down wins.
    push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b1, 1'b1);
    drain(50);
    idle(10);

    // Power-good timeout on rail 1.
    pg_ok = 3'b101;
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    push(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 9);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 11);
    pulse(1'b1, 1'b0);
    drain(200);
    pulse(1'b1, 1'b0);
    idle(20);
    check("fault_sticky", {30'd0, fault, 1'b0}, 32'd2);
    check("fault_rail",   {30'd0, fault_rail},  32'd1);
    push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b0, 1'b1);
    drain(50);
    pg_ok = 3'b111;
    idle(5);

    // Abort during rail 1 settle (two cycles into UP_SETTLE).
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    push(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 9);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6);
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6);
    push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b1, 1'b0);
    repeat (14) @(negedge clk);
    pd = 1'b1;
    @(negedge clk);
    pd = 1'b0;
    drain(200);
    idle(10);

    // Asynchronous reset while rail 0 waits for power-good.
    push(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    push(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_en",   {29'd0, rail_en}, 32'd0);
    check("async_reset_busy", {31'd0, busy},    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain(20);
    idle(10);

    // After reset the sequencer is back in OFF and sequences normally.
    up_seq();
`ifdef RAIL_SEQ_PG_MONITOR_EN
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0);
    @(negedge clk);
    pg_ok = 3'b011;
    repeat (2) @(negedge clk);
    check("pg_loss_before", {31'd0, fault}, 32'd0);
    @(negedge clk);
    check("pg_loss_fault", {31'd0, fault},      32'd1);
    check("pg_loss_rail",  {30'd0, fault_rail}, 32'd2);
    drain(20);
    pg_ok = 3'b111;
    push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    pulse(1'b0, 1'b1);
    drain(50);
`else
    @(negedge clk);
    pg_ok = 3'b011;
    idle(20);
    check("pg_loss_ignored", {31'd0, fault}, 32'd0);
    pg_ok = 3'b111;
    down_seq();
`endif
    idle(10);

    drain(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
